// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_e;

    // Read data returned to a requester whose access timed out.
    localparam logic [31:0] ARB_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch I, data D) for one shared single-port memory.
// D has priority; I is granted after STARVE_MAX consecutive D grants while I waits.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall_if,
    output logic        stall_mem,
    output logic        err
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] StarveMax = 3'(STARVE_MAX);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    arb_state_e       r_state;
    arb_state_e       w_state_next;
    logic [2:0]       r_starve;
    logic [WaitW-1:0] r_wait;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_i_rdata;
    logic [31:0]      r_d_rdata;
    logic             r_i_valid;
    logic             r_d_valid;
    logic             r_err;

    logic w_grant_i;
    logic w_grant_d;
    logic w_done;
    logic w_timeout;

    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req && !(i_req && (r_starve == StarveMax))) begin
                    w_grant_d    = 1'b1;
                    w_state_next = BUSY_D;
                end else if (i_req) begin
                    w_grant_i    = 1'b1;
                    w_state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else if (r_wait == WaitLast) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_wait      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;

            if (r_state == IDLE) begin
                if (!i_req || w_grant_i) begin
                    r_starve <= '0;
                end else if (w_grant_d && (r_starve != StarveMax)) begin
                    r_starve <= r_starve + 1'b1;
                end
            end

            if (w_grant_i || w_grant_d) begin
                r_mem_req  <= 1'b1;
                r_mem_we   <= w_grant_d & d_we;
                r_mem_addr <= w_grant_d ? d_addr : i_addr;
                r_wait     <= '0;
            end
            if (w_grant_d) begin
                r_mem_wdata <= d_wdata;
            end

            if ((r_state != IDLE) && !w_done && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end

            if (w_done || w_timeout) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                if (r_state == BUSY_I) begin
                    r_i_valid <= 1'b1;
                end else begin
                    r_d_valid <= 1'b1;
                end
            end

            // Writes complete without touching the held read data.
            if (w_done) begin
                if (r_state == BUSY_I) begin
                    r_i_rdata <= mem_rdata;
                end else if (!r_mem_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end

            if (w_timeout) begin
                r_err <= 1'b1;
                if (r_state == BUSY_I) begin
                    r_i_rdata <= ARB_ERR_RDATA;
                end else begin
                    r_d_rdata <= ARB_ERR_RDATA;
                end
            end
        end
    end

    always_comb begin
        mem_req   = r_mem_req;
        mem_we    = r_mem_we;
        mem_addr  = r_mem_addr;
        mem_wdata = r_mem_wdata;
        i_rdata   = r_i_rdata;
        i_valid   = r_i_valid;
        d_rdata   = r_d_rdata;
        d_valid   = r_d_valid;
        err       = r_err;
        stall_if  = i_req & ~r_i_valid;
        stall_mem = d_req & ~r_d_valid;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level arbitration model,
// preceded by directed scenarios for latency, priority, starvation, writes, timeout and reset.
module tb_mem_arbiter;

    localparam int unsigned StarveMaxP = 4;
    localparam int unsigned TimeoutP   = 16;
    localparam logic [31:0] ErrData    = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;

    mem_arbiter #(
        .STARVE_MAX(StarveMaxP),
        .TIMEOUT   (TimeoutP)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_valid  (i_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .err      (err)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: memory is either free or owned by one transaction.
    bit          m_free;
    int          m_owner;     // 1 = I, 2 = D
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    int          m_busy_cycles;
    int          m_starve;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;
    bit          m_err;
    bit          e_req;
    bit          e_iv;
    bit          e_dv;

    task automatic model_finish(input logic [31:0] data, input bit timed_out);
        if (m_owner == 1) begin
            e_iv     = 1'b1;
            m_irdata = data;
        end else begin
            e_dv = 1'b1;
            if (timed_out || !m_we) m_drdata = data;
        end
        m_free = 1'b1;
        e_req  = 1'b0;
    endtask

    // Predicts what the outputs show after the coming edge, given the inputs now applied.
    task automatic model_step();
        int win;
        e_iv = 1'b0;
        e_dv = 1'b0;
        if (!rst) begin
            m_free   = 1'b1;
            m_starve = 0;
            m_err    = 1'b0;
            m_irdata = '0;
            m_drdata = '0;
            e_req    = 1'b0;
            return;
        end
        if (m_free) begin
            win = 0;
            if (d_req && !(m_starve == int'(StarveMaxP) && i_req)) win = 2;
            else if (i_req) win = 1;
            if (!i_req || win == 1) m_starve = 0;
            else if (win == 2 && m_starve < int'(StarveMaxP)) m_starve++;
            if (win != 0) begin
                m_free        = 1'b0;
                m_owner       = win;
                m_busy_cycles = 0;
                m_addr        = (win == 2) ? d_addr : i_addr;
                m_we          = (win == 2) ? d_we : 1'b0;
                m_wdata       = d_wdata;
            end
            e_req = (win != 0);
        end else if (mem_ack) begin
            model_finish(mem_rdata, 1'b0);
        end else begin
            m_busy_cycles++;
            if (m_busy_cycles == int'(TimeoutP)) begin
                m_err = 1'b1;
                model_finish(ErrData, 1'b1);
            end else begin
                e_req = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs();
        check("mem_req", 32'(mem_req), 32'(e_req));
        if (e_req) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        check("i_valid", 32'(i_valid), 32'(e_iv));
        check("d_valid", 32'(d_valid), 32'(e_dv));
        check("i_rdata", i_rdata, m_irdata);
        check("d_rdata", d_rdata, m_drdata);
        check("err", 32'(err), 32'(m_err));
        check("stall_if", 32'(stall_if), 32'(i_req & ~e_iv));
        check("stall_mem", 32'(stall_mem), 32'(d_req & ~e_dv));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    int ack_cd = -1;

    initial begin
        int exp_win [6];
        int win;
        int cyc;

        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        // Fetch only, ack two cycles after mem_req.
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        check("if_mem_addr", mem_addr, 32'h10);
        check("if_stall", 32'(stall_if), 32'd1);
        tick();
        tick();
        check("if_stall_wait", 32'(stall_if), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        check("if_valid", 32'(i_valid), 32'd1);
        check("if_rdata", i_rdata, 32'h0050_0093);
        mem_ack = 1'b0; i_req = 1'b0;
        tick();

        // Data write.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE;
        tick();
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_wdata", mem_wdata, 32'hCAFE);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        check("wr_d_valid", 32'(d_valid), 32'd1);
        check("wr_d_rdata_kept", d_rdata, 32'd0);
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        tick();
        check("wr_pulse_once", 32'(d_valid), 32'd0);

        // Simultaneous requests: D first, I after the bubble.
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
        tick();
        check("sim_first_d", mem_addr, 32'h200);
        mem_ack = 1'b1; mem_rdata = 32'hA;
        tick();
        check("sim_d_valid", 32'(d_valid), 32'd1);
        check("sim_bubble", 32'(mem_req), 32'd0);
        mem_ack = 1'b0; d_req = 1'b0;
        tick();
        check("sim_then_i", mem_addr, 32'h100);
        mem_ack = 1'b1; mem_rdata = 32'hB;
        tick();
        mem_ack = 1'b0; i_req = 1'b0;
        tick();

        // Starvation: back-to-back D with I pending; fifth grant must go to I.
        exp_win = '{2, 2, 2, 2, 1, 2};
        i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            cyc = 0;
            while (!mem_req && cyc < 10) begin
                tick();
                cyc++;
            end
            win = (mem_addr[11:8] == 4'h4) ? 2 : 1;
            check($sformatf("starve_grant%0d", k), 32'(win), 32'(exp_win[k]));
            mem_ack = 1'b1; mem_rdata = $urandom;
            tick();
            mem_ack = 1'b0;
            if (d_valid) d_addr = 32'h400 + 32'(k + 1);
            if (i_valid) i_addr = 32'h310;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // Timeout: no ack ever arrives.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        tick();
        cyc = 0;
        while (mem_req && cyc < 40) begin
            cyc++;
            tick();
        end
        check("to_busy_cycles", 32'(cyc), 32'(TimeoutP));
        check("to_d_valid", 32'(d_valid), 32'd1);
        check("to_d_rdata", d_rdata, ErrData);
        check("to_err", 32'(err), 32'd1);
        d_req = 1'b0;
        tick();
        check("to_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a D access; a late ack must be ignored.
        d_req = 1'b1; d_addr = 32'h600;
        tick();
        rst = 1'b0;
        tick();
        check("mrst_mem_req", 32'(mem_req), 32'd0);
        check("mrst_mem_addr", mem_addr, 32'd0);
        check("mrst_mem_we", 32'(mem_we), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_d_valid", 32'(d_valid), 32'd0);
        check("mrst_d_rdata", d_rdata, 32'd0);
        rst = 1'b1; d_req = 1'b0; mem_ack = 1'b1;
        tick();
        check("mrst_late_ack", 32'(d_valid), 32'd0);
        mem_ack = 1'b0;
        tick();
        check("mrst_idle", 32'(mem_req), 32'd0);

        // Random traffic with a randomly slow (occasionally silent) memory.
        for (int c = 0; c < 3000; c++) begin
            if (i_req && i_valid) begin
                i_req  = ($urandom_range(0, 2) == 0);
                i_addr = $urandom;
            end else if (i_req && $urandom_range(0, 49) == 0) begin
                i_req = 1'b0;
            end else if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req  = 1'b1;
                i_addr = $urandom;
            end
            if (d_req && d_valid) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req   = 1'b1;
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (ack_cd < 0) ack_cd = ($urandom_range(0, 39) == 0) ? 1000 : $urandom_range(0, 4);
                if (ack_cd == 0) begin
                    mem_ack = 1'b1;
                    ack_cd  = -1;
                end else begin
                    ack_cd--;
                end
            end else begin
                ack_cd = -1;
                if ($urandom_range(0, 9) == 0) mem_ack = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive D grants while i_req is pending.
REQ-002 Parameter TIMEOUT, default 16: max cycles BUSY may wait for mem_ack.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low; sampled on posedge clk only.
REQ-005 i_req  in  1  fetch-side read request; held until i_valid.
REQ-006 i_addr  in  32  fetch address.
REQ-007 i_rdata  out  32  fetch read data; qualified by i_valid.
REQ-008 i_valid  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  MEM-stage request; held until d_valid.
REQ-010 d_we  in  1  1 = write, 0 = read.
REQ-011 d_addr, d_wdata  in  32 each  data address and write data.
REQ-012 d_rdata  out  32  data read result; qualified by d_valid.
REQ-013 d_valid  out  1  one-cycle data completion pulse.
REQ-014 mem_req  out  1  request to the shared single-port memory; held until mem_ack.
REQ-015 mem_we  out  1  registered write enable.
REQ-016 mem_addr, mem_wdata  out  32 each  registered address and write data.
REQ-017 mem_rdata  in  32  memory read data; valid while mem_ack = 1.
REQ-018 mem_ack  in  1  one-cycle completion from memory.
REQ-019 stall_if, stall_mem  out  1 each  pipeline stalls.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 FSM states are IDLE, BUSY_I, BUSY_D.
REQ-022 In IDLE with d_req = 1: grant D unless starve_cnt = STARVE_MAX and i_req = 1, in which case grant I.
REQ-023 In IDLE with only i_req = 1: grant I. With no request: stay in IDLE and keep mem_req = 0.
REQ-024 On a grant, the next state is BUSY_x; mem_req, mem_we and mem_addr are registered from the winner (plus mem_wdata for D); mem_we is forced to 0 for I.
REQ-025 In BUSY_x, mem_req = 1 and mem_addr/mem_we/mem_wdata stay constant until mem_ack.
REQ-026 On mem_ack in BUSY_x: register mem_rdata into x_rdata, pulse x_valid for exactly one cycle, return to IDLE.
REQ-027 x_rdata holds its value until the next completion for the same requester.
REQ-028 For D writes, d_valid pulses and d_rdata is unchanged.
REQ-029 Latency: request at cycle t (FSM in IDLE) -> mem_req = 1 at t+1; mem_ack at cycle a -> x_valid = 1 at a+1. The FSM is in IDLE at a+1, so the next grant occurs at a+2 at the earliest (minimum one-cycle bubble).
REQ-030 starve_cnt (3 bits) increments on each D grant while i_req = 1, saturates at STARVE_MAX, and clears on any I grant or when i_req = 0 in IDLE.
REQ-031 stall_if = i_req & ~i_valid; stall_mem = d_req & ~d_valid (combinational).
REQ-032 A wait counter clears on grant and increments each BUSY cycle without mem_ack.
REQ-033 When the wait counter reaches TIMEOUT: set err, drop mem_req, pulse x_valid with x_rdata = 32'hDEADBEEF, return to IDLE.
REQ-034 mem_ack while in IDLE is ignored.
REQ-035 A requester dropping x_req mid-BUSY does not abort the transaction: the memory access still completes and x_valid still pulses.
REQ-036 mem_ack and a timeout in the same cycle: mem_ack wins, err is not set.

Reset
REQ-037 When rst = 0 at a posedge: state = IDLE; mem_req, mem_we, i_valid, d_valid, err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; starve_cnt and wait counter = 0.
REQ-038 Reset asserted mid-BUSY abandons the transaction with no valid pulse; a mem_ack arriving after reset is ignored.

Structure
REQ-039 arb_state_e (IDLE, BUSY_I, BUSY_D) and the 32'hDEADBEEF error constant belong in riscv_pkg.
REQ-040 Single module, no sub-modules; counters and FSM live in one sequential block plus one combinational next-state block.

Verification
REQ-041 I-only: i_req=1, i_addr=0x10, mem_ack 2 cycles after mem_req with rdata 0x00500093 -> i_valid=1 one cycle later, i_rdata=0x00500093, stall_if high until then.
REQ-042 Simultaneous: i_req=d_req=1 in IDLE -> D granted (mem_addr=d_addr), I granted after the D completion plus the bubble.
REQ-043 Starvation: d_req held high with back-to-back requests for 6 grants, i_req=1 throughout -> 5th grant goes to I.
REQ-044 Write: d_we=1, d_addr=0x20, d_wdata=0xCAFE -> mem_we=1, mem_wdata=0xCAFE; d_valid pulses; d_rdata unchanged.
REQ-045 Timeout: mem_ack never arrives -> after 16 BUSY cycles err=1, x_valid pulses with 0xDEADBEEF, state returns to IDLE.
REQ-046 Reset mid-BUSY_D (rst=0 for 1 cycle) -> all outputs 0 next cycle; a later mem_ack produces no d_valid.
